// File: rtl/segment_decoder_pkg.sv
// Shared definitions for the seven-segment pattern decoder: glyph patterns,
// FSM state type and stability counter width.
package segment_decoder_pkg;

    // Stability counter width; the counter saturates at its all-ones value.
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Segment patterns, bit0 = a .. bit6 = g, active-high.
    localparam logic [6:0] PATTERN_BLANK = 7'h00;
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    // TRACK: waiting for the sampled pattern to settle.
    // LOCKED: the current pattern has been judged stable.
    typedef enum logic {
        ST_TRACK  = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/segment_decoder_if.sv
// Bus between the segment decoder and its surroundings.
// Handshake: the decoder raises out_valid with digit/blank/invalid when an
// event is pending and holds all four stable until a cycle with
// out_valid && out_ready; that cycle transfers the event. out_valid does not
// wait for out_ready. overrun is a sticky flag, not part of the handshake.
interface segment_decoder_if;

    logic [6:0]                    segments;
    logic                          out_ready;
    logic                          out_valid;
    logic [3:0]                    digit;
    logic                          blank;
    logic                          invalid;
    logic                          overrun;
    segment_decoder_pkg::state_t   state;

    // Environment side: drives the display pattern and consumes events.
    modport master (
        output segments, out_ready,
        input  out_valid, digit, blank, invalid, overrun, state
    );

    // Decoder side; state exposes the FSM for observation.
    modport slave (
        input  segments, out_ready,
        output out_valid, digit, blank, invalid, overrun, state
    );

endinterface

// File: rtl/segment_decoder_glyph_lut.sv
// Combinational seven-segment pattern to hex digit lookup.
// A..F glyphs decode only when SEGMENT_DECODER_HEX_EN is defined; otherwise
// they are reported as invalid.
module seg7_glyph_lut
    import segment_decoder_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       blank,
    output logic       invalid
);

    // Map a pattern to its digit; anything unlisted is invalid with digit 0.
    always_comb begin
        digit   = 4'd0;
        blank   = 1'b0;
        invalid = 1'b0;
        case (pattern)
            PATTERN_BLANK: blank = 1'b1;
            GLYPH_0: digit = 4'h0;
            GLYPH_1: digit = 4'h1;
            GLYPH_2: digit = 4'h2;
            GLYPH_3: digit = 4'h3;
            GLYPH_4: digit = 4'h4;
            GLYPH_5: digit = 4'h5;
            GLYPH_6: digit = 4'h6;
            GLYPH_7: digit = 4'h7;
            GLYPH_8: digit = 4'h8;
            GLYPH_9: digit = 4'h9;
`ifdef SEGMENT_DECODER_HEX_EN
            GLYPH_A: digit = 4'hA;
            GLYPH_B: digit = 4'hB;
            GLYPH_C: digit = 4'hC;
            GLYPH_D: digit = 4'hD;
            GLYPH_E: digit = 4'hE;
            GLYPH_F: digit = 4'hF;
`else
`endif
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/segment_decoder.sv
// Seven-segment display decoder with debounce. The pattern is registered,
// must stay unchanged for STABLE_CYCLES samples, and is then reported once
// as an event if it differs from the last accepted pattern.
// Optional build macro: SEGMENT_DECODER_HEX_EN enables A..F decoding.
module segment_decoder
    import segment_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
)(
    input  logic               clk,
    input  logic               rst,
    segment_decoder_if.slave   bus
);

    localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]       seg_q;
    logic [6:0]       last_q;
    logic [CNT_W-1:0] cnt_q;
    state_t           state_q;
    state_t           state_d;
    logic             seg_change;
    logic             lock;
    logic             new_event;
    logic             handshake;
    logic [3:0]       lut_digit;
    logic             lut_blank;
    logic             lut_invalid;
    logic             out_valid_q;
    logic [3:0]       digit_q;
    logic             blank_q;
    logic             invalid_q;
    logic             overrun_q;

    // True when the register is about to take a different pattern.
    assign seg_change = (bus.segments != seg_q);
    assign handshake  = out_valid_q && bus.out_ready;

    // Sample the pattern and count how long it has stayed unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= 7'h00;
            cnt_q <= '0;
        end else begin
            seg_q <= bus.segments;
            if (seg_change) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_TRACK;
        else     state_q <= state_d;
    end

    // FSM next state: lock once the count reaches its threshold, fall back
    // to tracking whenever the sampled pattern changes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_TRACK:  if (cnt_q == LOCK_CNT && !seg_change) state_d = ST_LOCKED;
            ST_LOCKED: if (seg_change) state_d = ST_TRACK;
            default:   state_d = ST_TRACK;
        endcase
    end

    // FSM outputs: acceptance moment and whether it is a new pattern.
    always_comb begin
        lock      = (state_q == ST_TRACK) && (cnt_q == LOCK_CNT);
        new_event = lock && (seg_q != last_q);
    end

    // Remember the most recently accepted pattern so repeats stay silent.
    always_ff @(posedge clk) begin
        if (rst)       last_q <= PATTERN_BLANK;
        else if (lock) last_q <= seg_q;
    end

    seg7_glyph_lut u_lut (
        .pattern (seg_q),
        .digit   (lut_digit),
        .blank   (lut_blank),
        .invalid (lut_invalid)
    );

    // Event holding register: load on a free slot or same-cycle handshake,
    // otherwise drop the new event and flag overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            digit_q     <= 4'd0;
            blank_q     <= 1'b0;
            invalid_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (new_event) begin
            if (!out_valid_q || handshake) begin
                out_valid_q <= 1'b1;
                digit_q     <= lut_digit;
                blank_q     <= lut_blank;
                invalid_q   <= lut_invalid;
            end else begin
                overrun_q   <= 1'b1;
            end
        end else if (handshake) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.digit     = digit_q;
    assign bus.blank     = blank_q;
    assign bus.invalid   = invalid_q;
    assign bus.overrun   = overrun_q;
    assign bus.state     = state_q;

endmodule
